// File: rtl/mem_copy_dma.sv
// rtl/mem_copy_dma.sv - word-by-word RAM copy engine alternating one READ and one WRITE cycle per word
module mem_copy_dma #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [ADDR_W:0]   len,
   input  logic              abort,
   input  logic [DATA_W-1:0] mem_out,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_in,
   output logic              mem_load,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_DONE
   } state_t;

   localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   src_ptr_q, src_ptr_d;
   logic [ADDR_W-1:0]   dst_ptr_q, dst_ptr_d;
   logic [ADDR_W:0]     remaining_q, remaining_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [ADDR_W:0]     len_sat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         src_ptr_q   <= '0;
         dst_ptr_q   <= '0;
         remaining_q <= '0;
         data_q      <= '0;
      end else begin
         state_q     <= state_d;
         src_ptr_q   <= src_ptr_d;
         dst_ptr_q   <= dst_ptr_d;
         remaining_q <= remaining_d;
         data_q      <= data_d;
      end
   end

   always_comb begin
      len_sat     = (len > MAX_LEN) ? MAX_LEN : len;
      state_d     = state_q;
      src_ptr_d   = src_ptr_q;
      dst_ptr_d   = dst_ptr_q;
      remaining_d = remaining_q;
      data_d      = data_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               src_ptr_d   = src_addr;
               dst_ptr_d   = dst_addr;
               remaining_d = len_sat;
               state_d     = (len_sat != '0) ? S_READ : S_DONE;
            end
         end
         S_READ: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               data_d  = mem_out;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            // The write itself is committed this edge even when aborting.
            src_ptr_d   = src_ptr_q + ADDR_W'(1);
            dst_ptr_d   = dst_ptr_q + ADDR_W'(1);
            remaining_d = remaining_q - (ADDR_W+1)'(1);
            if (abort) begin
               state_d = S_IDLE;
            end else if (remaining_q == (ADDR_W+1)'(1)) begin
               state_d = S_DONE;
            end else begin
               state_d = S_READ;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign mem_address = (state_q == S_WRITE) ? dst_ptr_q : src_ptr_q;
   assign mem_in      = data_q;
   assign mem_load    = (state_q == S_WRITE);
   assign busy        = (state_q == S_READ) || (state_q == S_WRITE);
   assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb/tb_mem_copy_dma.sv - randomized scoreboard bench for mem_copy_dma against a forward-copy RAM model
module tb_mem_copy_dma;

   localparam int AW    = 9;
   localparam int DW    = 16;
   localparam int DEPTH = 512;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] src_addr = '0;
   logic [AW-1:0] dst_addr = '0;
   logic [AW:0]   len = '0;
   logic [DW-1:0] mem_out;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_in;
   logic          mem_load;
   logic          busy;
   logic          done;

   logic [DW-1:0] ram [DEPTH];
   logic [DW-1:0] gold [DEPTH];
   logic          pre_we = 1'b0;
   logic [AW-1:0] pre_a = '0;
   logic [DW-1:0] pre_d = '0;

   typedef struct {
      int unsigned   addr;
      logic [DW-1:0] data;
   } wr_t;

   wr_t exp_wr[$];
   int  exp_done[$];
   int  checks = 0;
   int  errors = 0;
   int  busy_run = 0;
   wr_t mon_e;
   int  mon_d;

   mem_copy_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .src_addr    (src_addr),
      .dst_addr    (dst_addr),
      .len         (len),
      .abort       (abort),
      .mem_out     (mem_out),
      .mem_address (mem_address),
      .mem_in      (mem_in),
      .mem_load    (mem_load),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Behavioural RAM: combinational read, write on rising edge; pre_* preloads while idle.
   assign mem_out = ram[mem_address];
   always @(posedge clk) begin
      if (mem_load) ram[mem_address] <= mem_in;
      else if (pre_we) ram[pre_a] <= pre_d;
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Monitor: every write and every done pulse is matched against the scoreboard queues.
   always @(negedge clk) begin
      if (!rst_n) begin
         busy_run = 0;
      end else begin
         if (mem_load) begin
            if (exp_wr.size() == 0) begin
               chk("unexpected_write", 1, 0);
            end else begin
               mon_e = exp_wr.pop_front();
               chk("wr_addr", longint'(mem_address), longint'(mon_e.addr));
               chk("wr_data", longint'(mem_in), longint'(mon_e.data));
            end
         end
         if (done) begin
            if (exp_done.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               mon_d = exp_done.pop_front();
               chk("busy_cycles", busy_run, mon_d);
            end
            chk("busy_in_done", longint'(busy), 0);
            busy_run = 0;
         end else if (busy) begin
            busy_run++;
         end else begin
            busy_run = 0;
         end
      end
   end

   task automatic poke(input int a, input logic [DW-1:0] d);
      pre_a = AW'(a);
      pre_d = d;
      pre_we = 1'b1;
      gold[a] = d;
      @(posedge clk); #1;
      pre_we = 1'b0;
   endtask

   // Reference: ascending word-at-a-time copy, so overlapping dst>src propagates.
   task automatic model(input int s, input int d, input int n);
      for (int i = 0; i < n; i++) begin
         int sa;
         int da;
         sa = (s + i) % DEPTH;
         da = (d + i) % DEPTH;
         gold[da] = gold[sa];
         exp_wr.push_back('{da, gold[da]});
      end
   endtask

   task automatic issue(input int s, input int d, input int l);
      src_addr = AW'(s);
      dst_addr = AW'(d);
      len = (AW+1)'(l);
      start = 1'b1;
   endtask

   task automatic do_copy(input int s, input int d, input int l, input bit noise);
      int n;
      int cyc;
      n = (l > DEPTH) ? DEPTH : l;
      cyc = 0;
      model(s, d, n);
      exp_done.push_back(2 * n);
      issue(s, d, l);
      abort = noise;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      if (noise) begin
         src_addr = AW'($urandom);
         dst_addr = AW'($urandom);
         len = (AW+1)'($urandom);
      end
      if (n > 0) chk("busy_first_read", longint'(busy), 1);
      while (!done && cyc < 2 * n + 5) begin
         start = noise && (cyc % 3 == 1);
         @(posedge clk); #1;
         cyc++;
      end
      chk("done_cycle", cyc, 2 * n);
      chk("done_pulse", longint'(done), 1);
      start = noise;
      @(posedge clk); #1;
      start = 1'b0;
      chk("done_one_cycle", longint'(done), 0);
      chk("idle_after_done", longint'(busy), 0);
   endtask

   task automatic run_to_write(input int k, output int w);
      int cyc;
      cyc = 0;
      w = 0;
      while (cyc < 4 * k + 4) begin
         if (mem_load) begin
            w++;
            if (w == k) break;
         end
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic do_abort(input int s, input int d, input int l, input int k);
      int w;
      model(s, d, k);
      issue(s, d, l);
      @(posedge clk); #1;
      start = 1'b0;
      run_to_write(k, w);
      chk("abort_write_idx", w, k);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("busy_after_abort", longint'(busy), 0);
      chk("no_done_on_abort", longint'(done), 0);
      @(posedge clk); #1;
      chk("no_done_later", longint'(done), 0);
   endtask

   task automatic do_reset(input int s, input int d, input int l, input int k);
      int w;
      model(s, d, k - 1);
      issue(s, d, l);
      @(posedge clk); #1;
      start = 1'b0;
      run_to_write(k, w);
      chk("reset_write_idx", w, k);
      chk("mid_write_load", longint'(mem_load), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_async_load", longint'(mem_load), 0);
      chk("rst_async_busy", longint'(busy), 0);
      chk("rst_async_done", longint'(done), 0);
      chk("rst_async_addr", longint'(mem_address), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("idle_after_reset", longint'(busy | done), 0);
      chk("reset_pending_writes", exp_wr.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] pat [4];
      int diffs;
      pat[0] = 16'h00A1;
      pat[1] = 16'h00B2;
      pat[2] = 16'h00C3;
      pat[3] = 16'h00D4;

      #1;
      chk("reset_busy", longint'(busy), 0);
      chk("reset_done", longint'(done), 0);
      chk("reset_load", longint'(mem_load), 0);
      chk("reset_addr", longint'(mem_address), 0);
      chk("reset_mem_in", longint'(mem_in), 0);

      for (int i = 0; i < DEPTH; i++) poke(i, DW'($urandom));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 4; i++) poke(10 + i, pat[i]);
      do_copy(10, 100, 4, 1'b0);
      for (int i = 0; i < 4; i++) chk("basic_ram", longint'(ram[100 + i]), longint'(pat[i]));

      do_copy(510, 0, 3, 1'b0);
      do_copy(37, 300, 0, 1'b0);
      do_copy(20, 21, 5, 1'b0);
      do_copy(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)), 600, 1'b0);
      do_abort(30, 200, 5, 2);
      do_copy(40, 250, 3, 1'b1);

      for (int t = 0; t < 8; t++)
         do_copy(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
                 int'($urandom_range(0, 40)), bit'(t % 2));

      do_reset(60, 400, 6, 3);
      do_copy(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)), 7, 1'b1);

      repeat (3) @(posedge clk);
      #1;
      diffs = 0;
      for (int i = 0; i < DEPTH; i++) if (ram[i] !== gold[i]) diffs++;
      chk("ram_image_diffs", diffs, 0);
      chk("writes_left", exp_wr.size(), 0);
      chk("dones_left", exp_done.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
